arduino_cmd_rx: RTL and testbench

ARDUINO_CMD_RX -- requirements
Module: arduino_cmd_rx

---
 rtl/arduino_cmd_pkg.sv | 29 ++
 rtl/uart_rx_core.sv | 139 +++++++++++++
 rtl/arduino_cmd_rx.sv | 109 ++++++++++
 tb/tb_arduino_cmd_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/arduino_cmd_pkg.sv
// arduino_cmd_pkg
// Shared definitions for the Arduino command receiver:
//   - rx_state_e   : receiver FSM state encoding
//   - CMD_*_BIT    : bit positions of the motion flags inside a command byte
//   - cmd_is_legal : legality check applied to every well-framed byte
package arduino_cmd_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  localparam int unsigned CMD_FWD_BIT   = 0;
  localparam int unsigned CMD_LEFT_BIT  = 1;
  localparam int unsigned CMD_BACK_BIT  = 2;
  localparam int unsigned CMD_RIGHT_BIT = 3;

  // Upper nibble must be clear, and opposing directions may not be combined.
  // 8'h00 (stop) is legal.
  function automatic logic cmd_is_legal(input logic [7:0] cmd);
    return (cmd[7:4] == 4'h0) &&
           !(cmd[CMD_FWD_BIT]  && cmd[CMD_BACK_BIT]) &&
           !(cmd[CMD_LEFT_BIT] && cmd[CMD_RIGHT_BIT]);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core
// 8N1 LSB-first UART deserializer with a two-flop input synchronizer.
//
// state        | meaning
// -------------+------------------------------------------------------
// RX_IDLE      | line idle, waiting for synchronized rx to go low
// RX_START     | half-bit wait, then confirm the start bit is still low
// RX_DATA      | sample 8 data bits one bit period apart, LSB first
// RX_STOP      | sample the stop bit one bit period after the last data
// RX_WAIT_HIGH | framing error seen, wait for the line to return high
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous serial line (idle high)
//   rx_byte   out  deserialized byte, valid while byte_ok is high
//   byte_ok   out  one-cycle strobe: stop bit sampled high
//   frame_err out  one-cycle strobe: stop bit sampled low
//
// byte_ok / frame_err are combinational strobes in the stop-sample cycle so
// that the parent can register its outputs on the very next edge.
module uart_rx_core
  import arduino_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);

  logic            rx_s1;
  logic            rx_s2;
  logic            rx_sync;
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  assign rx_sync = rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RX_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Down-counter reaches zero on the cycle the line is to be sampled.
  assign tick = (timer_q == '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_d = RX_START;
          timer_d = HALF_LOAD;
        end
      end
      RX_START: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else if (rx_sync) begin
          state_d = RX_IDLE;
        end else begin
          state_d   = RX_DATA;
          timer_d   = BIT_LOAD;
          bit_idx_d = '0;
        end
      end
      RX_DATA: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else begin
          shift_d = {rx_sync, shift_q[7:1]};
          timer_d = BIT_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (!tick) begin
          timer_d = timer_q - TW'(1);
        end else if (rx_sync) begin
          byte_ok = 1'b1;
          state_d = RX_IDLE;
        end else begin
          frame_err = 1'b1;
          state_d   = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_sync) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign rx_byte = shift_q;

endmodule

// File: rtl/arduino_cmd_rx.sv
// arduino_cmd_rx
// Receives motion command bytes from an Arduino over UART, checks them for
// legality and presents the last legal command to manual_mode.
// Optional watchdog (macro ARDUINO_CMD_WATCHDOG_EN): forces the command to
// stop (8'h00) if no legal byte arrives within TIMEOUT_CYCLES clocks.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   rx              in   asynchronous UART line (idle high, 8N1, LSB first)
//   arduino_command out  registered command (bit0 fwd, bit1 left,
//                        bit2 back, bit3 right)
//   cmd_valid       out  one-cycle pulse, arduino_command updated
//   frame_err       out  one-cycle pulse, stop bit sampled low
//   cmd_err         out  one-cycle pulse, well-framed illegal byte
//   timeout         out  one-cycle pulse, watchdog forced stop (0 when the
//                        watchdog is not built)
module arduino_cmd_rx
  import arduino_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 50_000_000,
  parameter int unsigned BAUD           = 9600,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] arduino_command,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       cmd_err,
  output logic       timeout
);

  localparam int unsigned CLKS_PER_BIT =
    ((CLK_FREQ / BAUD) < 4) ? 4 : (CLK_FREQ / BAUD);

  logic [7:0] core_byte;
  logic       core_byte_ok;
  logic       core_frame_err;
  logic       accept;
  logic       reject;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_byte   (core_byte),
    .byte_ok   (core_byte_ok),
    .frame_err (core_frame_err)
  );

  assign accept = core_byte_ok &&  cmd_is_legal(core_byte);
  assign reject = core_byte_ok && !cmd_is_legal(core_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_valid <= accept;
      cmd_err   <= reject;
      frame_err <= core_frame_err;
    end
  end

`ifdef ARDUINO_CMD_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  // Counts down from TIMEOUT_CYCLES after each accepted byte and parks at
  // zero, so expiry fires once per accepted byte. Zero after reset means
  // nothing to time out.
  logic [WD_W-1:0] wd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      arduino_command <= 8'h00;
      wd_q            <= '0;
      timeout         <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (accept) begin
        arduino_command <= core_byte;
        wd_q            <= WD_W'(TIMEOUT_CYCLES);
      end else if (wd_q != '0) begin
        wd_q <= wd_q - WD_W'(1);
        if ((wd_q == WD_W'(1)) && (arduino_command != 8'h00)) begin
          arduino_command <= 8'h00;
          timeout         <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      arduino_command <= 8'h00;
    end else if (accept) begin
      arduino_command <= core_byte;
    end
  end

  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_arduino_cmd_rx.sv
// Self-checking bench for arduino_cmd_rx (10 clocks per bit, 500-cycle
// watchdog). A frame-level model predicts, for each frame sent, which pulse
// appears and when; a compare process checks every output on every cycle.
module tb_arduino_cmd_rx;

  localparam int unsigned CLK_FREQ = 1_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned TIMEOUT  = 500;
  localparam int CPB = 10;
  // line falls -> 2 sync flops -> idle detect -> half bit -> 8 data + stop
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;
`ifdef ARDUINO_CMD_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] arduino_command;
  logic       cmd_valid, frame_err, cmd_err, timeout;

  arduino_cmd_rx #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD           (BAUD),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .arduino_command (arduino_command),
    .cmd_valid       (cmd_valid),
    .frame_err       (frame_err),
    .cmd_err         (cmd_err),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    int         kind;   // 0 legal, 1 illegal, 2 framing error
    logic [7:0] data;
  } ev_t;

  ev_t        evq[$];
  int         cyc = 0;
  logic [7:0] m_cmd = 8'h00;
  bit         m_valid, m_ferr, m_cerr, m_to;
  int         m_last_valid = -1;

  int vectors = 0;
  int miscompares = 0;
  int n_valid = 0, n_ferr = 0, n_cerr = 0, n_to = 0;
  int last_valid_seen = -1;

  function automatic bit legal(input logic [7:0] d);
    return (d <= 8'd15) && ((d & 8'h05) != 8'h05) && ((d & 8'h0A) != 8'h0A);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // model: advance one clock
  always @(posedge clk) begin
    ev_t e;
    cyc++;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    m_cerr  = 1'b0;
    m_to    = 1'b0;
    if (rst) begin
      m_cmd = 8'h00;
      evq.delete();
      m_last_valid = -1;
    end else begin
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        case (e.kind)
          0: begin m_cmd = e.data; m_valid = 1'b1; m_last_valid = cyc; end
          1: m_cerr = 1'b1;
          default: m_ferr = 1'b1;
        endcase
      end
      if (WD_EN && !m_valid && m_last_valid >= 0 &&
          cyc == m_last_valid + int'(TIMEOUT) && m_cmd != 8'h00) begin
        m_cmd = 8'h00;
        m_to  = 1'b1;
      end
    end
  end

  // compare on the falling edge
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("arduino_command", 32'(arduino_command), 32'(m_cmd));
      chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("cmd_err",   32'(cmd_err),   32'(m_cerr));
      chk("timeout",   32'(timeout),   32'(m_to));
      if (cmd_valid) begin n_valid++; last_valid_seen = cyc; end
      if (frame_err) n_ferr++;
      if (cmd_err)   n_cerr++;
      if (timeout)   n_to++;
    end
  end

  // Returns the cycle at which the start bit was driven.
  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input int extra_low, output int start_cyc);
    ev_t e;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    rx = 1'b0;
    e.cyc  = start_cyc + LAT;
    e.data = d;
    if (!stop_b)       e.kind = 2;
    else if (legal(d)) e.kind = 0;
    else               e.kind = 1;
    evq.push_back(e);
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = d[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop_b;
    repeat (CPB + extra_low) @(posedge clk);
    #1 rx = 1'b1;
    repeat (CPB) @(posedge clk);
  endtask

  initial begin
    int s;
    int v0, f0, c0, t0;
    logic [7:0] d0c;

    repeat (5) @(posedge clk);
    #1;
    chk("lit_reset_cmd", 32'(arduino_command), 32'h00);
    chk("lit_reset_pulses", 32'({cmd_valid, frame_err, cmd_err, timeout}), 32'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // legal byte, latency pinned
    send_frame(8'h01, 1'b1, 0, s);
    chk("lit_cmd_01", 32'(arduino_command), 32'h01);
    chk("lit_valid_count_01", 32'(n_valid), 32'd1);
    chk("lit_latency_01", 32'(last_valid_seen - s), 32'd98);

    // illegal bytes
    send_frame(8'h05, 1'b1, 0, s);
    send_frame(8'h30, 1'b1, 0, s);
    chk("lit_cmd_err_count", 32'(n_cerr), 32'd2);
    chk("lit_cmd_after_illegal", 32'(arduino_command), 32'h01);

    // framing error with held-low line
    send_frame(8'h03, 1'b0, 50, s);
    chk("lit_frame_err_count", 32'(n_ferr), 32'd1);
    chk("lit_cmd_after_ferr", 32'(arduino_command), 32'h01);
    send_frame(8'h09, 1'b1, 0, s);
    chk("lit_cmd_09", 32'(arduino_command), 32'h09);

    // two-cycle glitch on idle line
    v0 = n_valid; f0 = n_ferr; c0 = n_cerr;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
    chk("lit_glitch_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_cerr - c0)), 32'd0);

    // repeated identical byte still pulses; then watchdog window
    send_frame(8'h02, 1'b1, 0, s);
    send_frame(8'h02, 1'b1, 0, s);
    chk("lit_repeat_valid", 32'(last_valid_seen - s), 32'd98);
    t0 = n_to;
    repeat (520) @(posedge clk);
    chk("lit_wd_cmd", 32'(arduino_command), WD_EN ? 32'h00 : 32'h02);
    chk("lit_wd_timeouts", 32'(n_to - t0), WD_EN ? 32'd1 : 32'd0);

    // reset in the middle of a frame
    send_frame(8'h08, 1'b1, 0, s);
    chk("lit_cmd_08", 32'(arduino_command), 32'h08);
    v0 = n_valid; f0 = n_ferr; c0 = n_cerr;
    d0c = 8'h0C;
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 rx = d0c[i];
      repeat (CPB) @(posedge clk);
    end
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    chk("lit_midreset_cmd", 32'(arduino_command), 32'h00);
    chk("lit_midreset_pulses", 32'((n_valid - v0) + (n_ferr - f0) + (n_cerr - c0)), 32'd0);
    send_frame(8'h0C, 1'b1, 0, s);
    chk("lit_cmd_0c", 32'(arduino_command), 32'h0C);
    chk("lit_latency_0c", 32'(last_valid_seen - s), 32'd98);

    repeat (20) @(posedge clk);
    chk("lit_model_drained", 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
